accum_tile_serializer: RTL and testbench

- Downstream stage of the complex accumulator array.
- Captures each finished 4x4 complex_t output tile when the accumulator's output_valid pulses, and buffers it in a small slot FIFO.
- Drains the tile as two 512-bit lines over a valid/ready stream towards the AFU write path.
- The accumulator has no backpressure, so this block owns overflow detection.

---
 rtl/accum_tile_serializer.sv | 147 ++++++++++++++
 tb/tb_accum_tile_serializer.sv | 304 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/accum_tile_serializer.sv
// accum_tile_serializer
//   Captures finished 4x4 complex tiles from the accumulator array into a small
//   slot FIFO and drains each tile as two 512-bit lines over a valid/ready
//   stream. Overflow (tile arriving while every slot is full) is sticky.
//
//   Handshake: a line transfers on a rising clk edge where out_valid and
//   out_ready are both 1. Once out_valid is raised, out_data and out_last stay
//   stable and out_valid stays high until that transfer happens (reset aside).
//
//   Optional build macro SERIALIZER_PERF_EN adds the drop_count and
//   stall_cycles counter outputs.
module accum_tile_serializer #(
  parameter int NUM_SLOTS = 2,
  parameter int LINE_W    = 512
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [0:3][0:3][63:0]   in_tile,
  input  logic                    in_valid,
  output logic [LINE_W-1:0]       out_data,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic                    out_last,
  output logic                    overflow,
  output logic                    busy
`ifdef SERIALIZER_PERF_EN
  ,
  output logic [15:0]             drop_count,
  output logic [31:0]             stall_cycles
`endif
);

  typedef logic [0:3][0:3][63:0] tile_t;
  typedef enum logic [1:0] {S_IDLE = 2'd0, S_LINE0 = 2'd1, S_LINE1 = 2'd2} state_t;

  localparam int PTR_W = (NUM_SLOTS > 1) ? $clog2(NUM_SLOTS) : 1;
  localparam logic [PTR_W-1:0] LAST_PTR = PTR_W'(NUM_SLOTS - 1);
  localparam logic [2:0]       SLOTS_C  = 3'(NUM_SLOTS);

  state_t              state_q, state_d;
  logic [PTR_W-1:0]    wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]    rd_ptr_q, rd_ptr_d;
  logic [2:0]          count_q, count_d;
  logic                out_valid_q, out_valid_d;
  logic                out_last_q, out_last_d;
  logic [LINE_W-1:0]   out_data_q, out_data_d;
  logic                overflow_q, overflow_d;
  tile_t               slot_q [NUM_SLOTS];

  logic                hs, pop, cap, drop;
  tile_t               head_tile;

  function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] p);
    return (p == LAST_PTR) ? '0 : p + 1'b1;
  endfunction

  // Occupancy bookkeeping and line-sequencing FSM next state.
  always_comb begin
    hs          = out_valid_q && out_ready;
    pop         = hs && (state_q == S_LINE1);
    // A final-line transfer frees a slot in the same cycle, so a full buffer
    // can still take a tile then.
    cap         = in_valid && ((count_q < SLOTS_C) || pop);
    drop        = in_valid && !cap;
    count_d     = count_q + {2'b00, cap} - {2'b00, pop};
    wr_ptr_d    = cap ? next_ptr(wr_ptr_q) : wr_ptr_q;
    rd_ptr_d    = pop ? next_ptr(rd_ptr_q) : rd_ptr_q;
    overflow_d  = overflow_q || drop;
    state_d     = state_q;
    case (state_q)
      S_IDLE:  if (count_d != 3'd0) state_d = S_LINE0;
      S_LINE0: if (hs) state_d = S_LINE1;
      S_LINE1: if (hs) state_d = (count_d != 3'd0) ? S_LINE0 : S_IDLE;
      default: state_d = S_IDLE;
    endcase
    out_valid_d = (state_d != S_IDLE);
    out_last_d  = (state_d == S_LINE1);
  end

  // Registered line data for the next state; a tile written this cycle into
  // the slot about to be read is forwarded directly from in_tile.
  always_comb begin
    head_tile = slot_q[rd_ptr_d];
    if (cap && (wr_ptr_q == rd_ptr_d)) head_tile = in_tile;
    out_data_d = '0;
    for (int r = 0; r < 2; r++) begin
      for (int c = 0; c < 4; c++) begin
        if (state_d == S_LINE0) out_data_d[64*(r*4+c) +: 64] = head_tile[r][c];
        else if (state_d == S_LINE1) out_data_d[64*(r*4+c) +: 64] = head_tile[r+2][c];
      end
    end
  end

  // Control and output registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= S_IDLE;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      out_valid_q <= 1'b0;
      out_last_q  <= 1'b0;
      out_data_q  <= '0;
      overflow_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
      out_valid_q <= out_valid_d;
      out_last_q  <= out_last_d;
      out_data_q  <= out_data_d;
      overflow_q  <= overflow_d;
    end
  end

  // Tile storage; contents survive reset and are only meaningful while counted.
  always_ff @(posedge clk) begin
    if (cap) slot_q[wr_ptr_q] <= in_tile;
  end

  assign out_data  = out_data_q;
  assign out_valid = out_valid_q;
  assign out_last  = out_last_q;
  assign overflow  = overflow_q;
  assign busy      = (count_q != 3'd0) || (state_q != S_IDLE);

`ifdef SERIALIZER_PERF_EN
  logic [15:0] drop_count_q;
  logic [31:0] stall_cycles_q;

  // Saturating drop counter and wrapping stall counter.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      drop_count_q   <= '0;
      stall_cycles_q <= '0;
    end else begin
      if (drop && (drop_count_q != 16'hFFFF)) drop_count_q <= drop_count_q + 16'd1;
      if (out_valid_q && !out_ready) stall_cycles_q <= stall_cycles_q + 32'd1;
    end
  end

  assign drop_count   = drop_count_q;
  assign stall_cycles = stall_cycles_q;
`endif

endmodule

// File: tb/tb_accum_tile_serializer.sv
// Bench for accum_tile_serializer: a line-queue reference model checked every
// cycle, a constant table for the known-pattern tile, and directed sequences
// for backpressure, overflow, full-with-reuse, async reset and streaming.
module tb_accum_tile_serializer;

  localparam int NUM_SLOTS = 2;
  typedef logic [0:3][0:3][63:0] tile_t;
  typedef struct {
    int          line;
    int          k;
    logic [63:0] exp;
  } vec_t;

  // ---------------- clock / reset ----------------
  logic         clk = 1'b0;
  logic         reset = 1'b0;
  tile_t        in_tile = '0;
  logic         in_valid = 1'b0;
  logic [511:0] out_data;
  logic         out_valid;
  logic         out_ready = 1'b0;
  logic         out_last;
  logic         overflow;
  logic         busy;
`ifdef SERIALIZER_PERF_EN
  logic [15:0]  drop_count;
  logic [31:0]  stall_cycles;
`endif

  always #5 clk = ~clk;

  accum_tile_serializer #(.NUM_SLOTS(NUM_SLOTS), .LINE_W(512)) dut (
    .clk       (clk),
    .reset     (reset),
    .in_tile   (in_tile),
    .in_valid  (in_valid),
    .out_data  (out_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_last  (out_last),
    .overflow  (overflow),
    .busy      (busy)
`ifdef SERIALIZER_PERF_EN
    ,
    .drop_count   (drop_count),
    .stall_cycles (stall_cycles)
`endif
  );

  // ---------------- scoreboard state ----------------
  int           checks = 0;
  int           errors = 0;
  logic [512:0] exp_q[$];   // {last, line data}, head = line currently offered
  bit           m_ovf = 0;
  int           m_drops = 0;
  int           m_stall = 0;
  int           dut_lines = 0;

  task automatic chk(input string name, input logic [511:0] act, input logic [511:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Line h of a tile: element [r][c] with r in {2h, 2h+1} lands at index (r%2)*4+c.
  function automatic logic [511:0] pack_line(input tile_t t, input int h);
    logic [511:0] l;
    l = '0;
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++)
        if (r / 2 == h) l[((r % 2) * 4 + c) * 64 +: 64] = t[r][c];
    return l;
  endfunction

  function automatic tile_t rand_tile();
    tile_t t;
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++)
        t[r][c] = {$urandom, $urandom};
    return t;
  endfunction

  task automatic check_outputs();
    chk("out_valid", {511'd0, out_valid}, {511'd0, exp_q.size() != 0});
    chk("busy", {511'd0, busy}, {511'd0, exp_q.size() != 0});
    chk("overflow", {511'd0, overflow}, {511'd0, m_ovf});
    if (exp_q.size() != 0) begin
      chk("out_data", out_data, exp_q[0][511:0]);
      chk("out_last", {511'd0, out_last}, {511'd0, exp_q[0][512]});
    end
  endtask

  // ---------------- driver: one clock with model update ----------------
  task automatic tick();
    bit hs, fin, acc;
    int tiles;
    hs    = (exp_q.size() != 0) && out_ready;
    fin   = hs && exp_q[0][512];
    tiles = (exp_q.size() + 1) / 2;
    acc   = in_valid && ((tiles < NUM_SLOTS) || fin);
    if ((exp_q.size() != 0) && !out_ready) m_stall++;
    if (out_valid && out_ready) dut_lines++;
    @(posedge clk);
    if (hs) void'(exp_q.pop_front());
    if (acc) begin
      exp_q.push_back({1'b0, pack_line(in_tile, 0)});
      exp_q.push_back({1'b1, pack_line(in_tile, 1)});
    end
    if (in_valid && !acc) begin
      m_ovf = 1;
      if (m_drops < 65535) m_drops++;
    end
    #1;
    check_outputs();
  endtask

  task automatic model_clear();
    exp_q.delete();
    m_ovf   = 0;
    m_drops = 0;
    m_stall = 0;
  endtask

  task automatic do_reset();
    reset = 1'b0;
    model_clear();
    @(posedge clk);
    @(posedge clk);
    #1;
    reset = 1'b1;
    check_outputs();
  endtask

  // ---------------- watchdog ----------------
  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  // ---------------- test sequence ----------------
  initial begin
    vec_t         vecs[7];
    tile_t        t;
    logic [511:0] line0, line1, held;
    logic         held_last;
    int           bubbles;

    // Element [r][c] of the known tile: real = 16r+c, imag = ~(16r+c).
    vecs[0] = '{0, 0, 64'h00000000_FFFFFFFF};
    vecs[1] = '{0, 3, 64'h00000003_FFFFFFFC};
    vecs[2] = '{0, 4, 64'h00000010_FFFFFFEF};
    vecs[3] = '{0, 7, 64'h00000013_FFFFFFEC};
    vecs[4] = '{1, 0, 64'h00000020_FFFFFFDF};
    vecs[5] = '{1, 5, 64'h00000031_FFFFFFCE};
    vecs[6] = '{1, 7, 64'h00000033_FFFFFFCC};

    // Reset state while reset is held low.
    #12;
    chk("rst out_valid", {511'd0, out_valid}, 512'd0);
    chk("rst out_last", {511'd0, out_last}, 512'd0);
    chk("rst overflow", {511'd0, overflow}, 512'd0);
    chk("rst busy", {511'd0, busy}, 512'd0);
    chk("rst out_data", out_data, 512'd0);
`ifdef SERIALIZER_PERF_EN
    chk("rst drop_count", {496'd0, drop_count}, 512'd0);
    chk("rst stall_cycles", {480'd0, stall_cycles}, 512'd0);
`endif
    @(posedge clk);
    #1;
    reset = 1'b1;
    tick();

    // Single known tile with out_ready held high.
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++)
        t[r][c] = {32'(16 * r + c), ~32'(16 * r + c)};
    in_tile = t; in_valid = 1'b1; out_ready = 1'b1;
    tick();
    in_valid = 1'b0;
    chk("lat out_valid", {511'd0, out_valid}, {511'd0, 1'b1});
    chk("lat out_last0", {511'd0, out_last}, 512'd0);
    line0 = out_data;
    tick();
    chk("lat out_last1", {511'd0, out_last}, {511'd0, 1'b1});
    line1 = out_data;
    tick();
    chk("done busy", {511'd0, busy}, 512'd0);
    chk("done out_valid", {511'd0, out_valid}, 512'd0);
    for (int i = 0; i < 7; i++) begin
      logic [511:0] l;
      l = (vecs[i].line == 0) ? line0 : line1;
      chk($sformatf("table line%0d k%0d", vecs[i].line, vecs[i].k),
          {448'd0, l[64 * vecs[i].k +: 64]}, {448'd0, vecs[i].exp});
    end

    // Backpressure in LINE0 for 5 cycles.
    out_ready = 1'b0; in_tile = rand_tile(); in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    held = out_data; held_last = out_last;
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("bp data", out_data, held);
      chk("bp last", {511'd0, out_last}, {511'd0, held_last});
    end
    out_ready = 1'b1;
    tick();
    chk("bp accept", {511'd0, out_last}, {511'd0, 1'b1});
    tick(); tick();

    // Overflow: three tiles into two slots with no drain.
    out_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      in_tile = rand_tile(); in_valid = 1'b1;
      tick();
    end
    in_valid = 1'b0;
    chk("ovf set", {511'd0, overflow}, {511'd0, 1'b1});
    dut_lines = 0; out_ready = 1'b1;
    repeat (8) tick();
    chk("ovf lines", 512'(dut_lines), 512'd4);
`ifdef SERIALIZER_PERF_EN
    chk("ovf drop_count", {496'd0, drop_count}, 512'd1);
`endif
    do_reset();

    // Full buffer, capture in the same cycle as the final-line handshake.
    out_ready = 1'b0;
    for (int i = 0; i < 2; i++) begin
      in_tile = rand_tile(); in_valid = 1'b1;
      tick();
    end
    in_valid = 1'b0; out_ready = 1'b1;
    tick();
    in_tile = rand_tile(); in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    chk("reuse overflow", {511'd0, overflow}, 512'd0);
    dut_lines = 0;
    repeat (8) tick();
    chk("reuse lines", 512'(dut_lines), 512'd4);

    // Asynchronous reset while in LINE1 with another tile queued.
    out_ready = 1'b0;
    for (int i = 0; i < 2; i++) begin
      in_tile = rand_tile(); in_valid = 1'b1;
      tick();
    end
    in_valid = 1'b0; out_ready = 1'b1;
    tick();
    chk("pre-rst last", {511'd0, out_last}, {511'd0, 1'b1});
    #2;
    reset = 1'b0;
    #1;
    chk("async rst valid", {511'd0, out_valid}, 512'd0);
    chk("async rst busy", {511'd0, busy}, 512'd0);
    model_clear();
    @(posedge clk);
    #1;
    reset = 1'b1;
    dut_lines = 0;
    repeat (6) tick();
    chk("post-rst lines", 512'(dut_lines), 512'd0);
    in_tile = rand_tile(); in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    repeat (3) tick();

    // Continuous stream: a tile every 2 cycles, 100 tiles.
    bubbles = 0;
    for (int i = 0; i < 200; i++) begin
      in_valid = (i % 2 == 0);
      in_tile  = rand_tile();
      tick();
      if (!out_valid) bubbles++;
    end
    in_valid = 1'b0;
    chk("stream bubbles", 512'(bubbles), 512'd0);
    chk("stream overflow", {511'd0, overflow}, 512'd0);
    repeat (3) tick();

    // Randomized traffic against the model.
    do_reset();
    for (int i = 0; i < 400; i++) begin
      in_valid  = ($urandom_range(0, 2) == 0);
      in_tile   = rand_tile();
      out_ready = ($urandom_range(0, 3) != 0);
      tick();
    end
    in_valid = 1'b0; out_ready = 1'b1;
    repeat (12) tick();
`ifdef SERIALIZER_PERF_EN
    chk("rand drop_count", {496'd0, drop_count}, 512'(m_drops));
    chk("rand stall_cycles", {480'd0, stall_cycles}, 512'(m_stall));
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
